// File: rtl/prbs_checker_pkg.sv
// Shared constants for the 4-bit Fibonacci PRPG link checker.
// State codes, default LFSR geometry and the reference pattern.
package prbs_checker_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_FILL   = 2'd0;
   localparam state_t ST_SYNC   = 2'd1;
   localparam state_t ST_LOCKED = 2'd2;

   localparam int PRBS_WIDTH = 4;
   localparam int PRBS_TAP_A = 0;
   localparam int PRBS_TAP_B = 1;

   // one full period, first transmitted bit in the MSB
   localparam logic [14:0] PRBS_PATTERN = 15'b111100010011010;

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module prbs_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             ini_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge ini_n) begin
      if (!ini_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial checker for the 4-bit Fibonacci PRPG stream.
// Fills, syncs on din, then free-runs its reference and counts bit errors.
module prbs_checker
   import prbs_checker_pkg::*;
#(
   parameter int WIDTH    = PRBS_WIDTH,
   parameter int TAP_A    = PRBS_TAP_A,
   parameter int TAP_B    = PRBS_TAP_B,
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             ini_n,
   input  logic             din_valid,
   input  logic             din,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam int FW = $clog2(WIDTH + 1);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(LOSS_CNT + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [GW-1:0]    good_q, good_d;
   logic [BW-1:0]    bad_q, bad_d;
   logic             err_q, err_d;
   logic             exp_bit;
   logic             err_inc;
   logic             bit_inc;

   assign exp_bit = hist_q[TAP_A] ^ hist_q[TAP_B];

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      good_d  = good_q;
      bad_d   = bad_q;
      err_d   = 1'b0;
      err_inc = 1'b0;
      bit_inc = 1'b0;
      if (din_valid) begin
         case (state_q)
            ST_FILL: begin
               hist_d = {din, hist_q[WIDTH-1:1]};
               if (fill_q == FW'(WIDTH - 1)) begin
                  state_d = ST_SYNC;
                  fill_d  = '0;
                  good_d  = '0;
               end else begin
                  fill_d = fill_q + FW'(1);
               end
            end
            ST_SYNC: begin
               hist_d = {din, hist_q[WIDTH-1:1]};
               // an all-zero history predicts zeros forever
               if ((din == exp_bit) && (|hist_q)) begin
                  if (good_q == GW'(LOCK_CNT - 1)) begin
                     state_d = ST_LOCKED;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     good_d = good_q + GW'(1);
                  end
               end else begin
                  good_d = '0;
               end
            end
            ST_LOCKED: begin
               bit_inc = 1'b1;
               hist_d  = {exp_bit, hist_q[WIDTH-1:1]};
               if (din != exp_bit) begin
                  err_d   = 1'b1;
                  err_inc = 1'b1;
                  if (bad_q == BW'(LOSS_CNT - 1)) begin
                     state_d = ST_SYNC;
                     bad_d   = '0;
                     good_d  = '0;
                     hist_d  = {din, hist_q[WIDTH-1:1]};
                  end else begin
                     bad_d = bad_q + BW'(1);
                  end
               end else begin
                  bad_d = '0;
               end
            end
            default: begin
               state_d = ST_FILL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge ini_n) begin
      if (!ini_n) begin
         state_q <= ST_FILL;
         hist_q  <= '0;
         fill_q  <= '0;
         good_q  <= '0;
         bad_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
      end
   end

   prbs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .ini_n (ini_n),
      .inc   (err_inc),
      .clr   (clr_cnt),
      .cnt   (err_cnt)
   );

   prbs_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
      .clk   (clk),
      .ini_n (ini_n),
      .inc   (bit_inc),
      .clr   (clr_cnt),
      .cnt   (bit_cnt)
   );

   assign locked = (state_q == ST_LOCKED);
   assign err    = err_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: randomised and directed stream scenarios
// compared against a bit-level behavioural model of the link receiver.
module tb_prbs_checker;
   import prbs_checker_pkg::*;

   localparam int CW     = 4;
   localparam int LOCK_N = 8;
   localparam int LOSS_N = 3;
   localparam int CMAX   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          ini_n;
   logic          din_valid;
   logic          din;
   logic          clr_cnt;
   logic          locked;
   logic          err;
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] bit_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int gi;

   // model: mode 0 fill, 1 sync, 2 locked; last four line bits, oldest first
   int m_mode, m_fill, m_good, m_bad, m_errc, m_bitc;
   bit m_err;
   bit m_hist[$];

   always #5 clk = ~clk;

   prbs_checker #(.CNT_W(CW)) dut (
      .clk       (clk),
      .ini_n     (ini_n),
      .din_valid (din_valid),
      .din       (din),
      .clr_cnt   (clr_cnt),
      .locked    (locked),
      .err       (err),
      .err_cnt   (err_cnt),
      .bit_cnt   (bit_cnt)
   );

   function automatic bit pat(int i);
      logic [14:0] p;
      p = PRBS_PATTERN;
      return p[14 - (i % 15)];
   endfunction

   task automatic model_reset();
      m_mode = 0; m_fill = 0; m_good = 0; m_bad = 0;
      m_errc = 0; m_bitc = 0; m_err = 1'b0;
      m_hist.delete();
      repeat (4) m_hist.push_back(1'b0);
   endtask

   task automatic model_step(bit v, bit d, bit c);
      bit pred;
      bit nxt;
      m_err = 1'b0;
      if (v) begin
         pred = m_hist[0] ^ m_hist[1];
         nxt  = d;
         if (m_mode == 0) begin
            m_fill++;
            if (m_fill == 4) begin m_mode = 1; m_good = 0; end
         end else if (m_mode == 1) begin
            if (d == pred && (m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3]))
               m_good++;
            else
               m_good = 0;
            if (m_good == LOCK_N) begin m_mode = 2; m_bad = 0; end
         end else begin
            if (m_bitc < CMAX) m_bitc++;
            if (d != pred) begin
               m_err = 1'b1;
               if (m_errc < CMAX) m_errc++;
               m_bad++;
            end else begin
               m_bad = 0;
            end
            if (m_bad == LOSS_N) begin
               m_mode = 1; m_good = 0; m_bad = 0;
            end else begin
               nxt = pred;
            end
         end
         void'(m_hist.pop_front());
         m_hist.push_back(nxt);
      end
      if (c) begin m_errc = 0; m_bitc = 0; end
   endtask

   task automatic drive(bit v, bit d, bit c);
      @(negedge clk);
      din_valid = v; din = d; clr_cnt = c;
      @(posedge clk);
      #1;
      model_step(v, d, c);
   endtask

   task automatic drive_clean(bit v, bit flip, bit c);
      bit d;
      d = pat(gi) ^ flip;
      if (v) gi++;
      drive(v, d, c);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      ini_n = 1'b0; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      ini_n = 1'b1;
      gi = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
      n_cmp++;
      if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
      n_cmp++;
      if (err_cnt !== '0) begin n_bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      n_cmp++;
      if (bit_cnt !== '0) begin n_bad++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
   endtask

   task automatic test_clean_lock();
      apply_reset();
      for (int i = 0; i < 30; i++) begin
         drive_clean(1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (locked !== (m_mode == 2) || err !== m_err ||
             err_cnt !== CW'(m_errc) || bit_cnt !== CW'(m_bitc)) begin
            n_bad++;
            $display("FAIL clean_lock bit=%0d got l=%b e=%b ec=%0d bc=%0d exp l=%b e=%b ec=%0d bc=%0d",
                     i, locked, err, err_cnt, bit_cnt, m_mode == 2, m_err, m_errc, m_bitc);
         end
         if (i == 10 || i == 11) begin
            n_cmp++;
            if (locked !== (i == 11)) begin
               n_bad++;
               $display("FAIL lock_edge bit=%0d got=%b exp=%b", i, locked, i == 11);
            end
         end
      end
      n_cmp++;
      if (err_cnt !== '0 || bit_cnt !== CW'(CMAX)) begin
         n_bad++;
         $display("FAIL clean_counts got ec=%0d bc=%0d exp ec=0 bc=%0d", err_cnt, bit_cnt, CMAX);
      end
   endtask

   task automatic test_single_flip();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         drive_clean(1'b1, i == 4, 1'b0);
         if (err === 1'b1) pulses++;
         n_cmp++;
         if (locked !== (m_mode == 2) || err !== m_err || err_cnt !== CW'(m_errc)) begin
            n_bad++;
            $display("FAIL single_flip bit=%0d got l=%b e=%b ec=%0d exp l=%b e=%b ec=%0d",
                     i, locked, err, err_cnt, m_mode == 2, m_err, m_errc);
         end
      end
      n_cmp++;
      if (pulses != 1 || err_cnt !== CW'(1) || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL single_flip_total got pulses=%0d ec=%0d l=%b exp 1 1 1", pulses, err_cnt, locked);
      end
   endtask

   task automatic test_loss_of_lock();
      int budget;
      for (int i = 0; i < 3; i++) begin
         drive_clean(1'b1, 1'b1, 1'b0);
         n_cmp++;
         if (locked !== (i < 2) || err !== 1'b1 || err_cnt !== CW'(m_errc)) begin
            n_bad++;
            $display("FAIL loss bit=%0d got l=%b e=%b ec=%0d exp l=%b e=1 ec=%0d",
                     i, locked, err, err_cnt, i < 2, m_errc);
         end
      end
      n_cmp++;
      if (err_cnt !== CW'(4)) begin
         n_bad++;
         $display("FAIL loss_err_cnt got=%0d exp=4", err_cnt);
      end
      budget = 0;
      while (locked !== 1'b1 && budget < 40) begin
         drive_clean(1'b1, 1'b0, 1'b0);
         budget++;
         n_cmp++;
         if (locked !== (m_mode == 2) || err !== 1'b0) begin
            n_bad++;
            $display("FAIL relock bit=%0d got l=%b e=%b exp l=%b e=0", budget, locked, err, m_mode == 2);
         end
      end
      n_cmp++;
      if (locked !== 1'b1) begin
         n_bad++;
         $display("FAIL relock_timeout got l=%b exp l=1 within 40 bits", locked);
      end
   endtask

   task automatic test_all_zero();
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (locked !== 1'b0 || err !== 1'b0 || locked !== (m_mode == 2)) begin
            n_bad++;
            $display("FAIL all_zero bit=%0d got l=%b e=%b exp l=0 e=0", i, locked, err);
         end
      end
   endtask

   task automatic test_gapped();
      int nvalid;
      apply_reset();
      nvalid = 0;
      for (int i = 0; i < 60; i++) begin
         drive_clean(i[0] == 1'b0, 1'b0, 1'b0);
         if (i[0] == 1'b0) nvalid++;
         n_cmp++;
         if (locked !== (m_mode == 2) || err !== 1'b0 ||
             err_cnt !== CW'(m_errc) || bit_cnt !== CW'(m_bitc) ||
             locked !== (nvalid >= 12)) begin
            n_bad++;
            $display("FAIL gapped cyc=%0d got l=%b e=%b ec=%0d bc=%0d exp l=%b e=0 ec=%0d bc=%0d",
                     i, locked, err, err_cnt, bit_cnt, nvalid >= 12, m_errc, m_bitc);
         end
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 20; k++) begin
         for (int j = 0; j < 3; j++) begin
            drive_clean(1'b1, j == 0, 1'b0);
            n_cmp++;
            if (locked !== (m_mode == 2) || err !== m_err || err_cnt !== CW'(m_errc)) begin
               n_bad++;
               $display("FAIL saturation err=%0d got l=%b e=%b ec=%0d exp l=%b e=%b ec=%0d",
                        k, locked, err, err_cnt, m_mode == 2, m_err, m_errc);
            end
         end
      end
      n_cmp++;
      if (err_cnt !== CW'(CMAX) || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL saturation_hold got ec=%0d l=%b exp ec=%0d l=1", err_cnt, locked, CMAX);
      end
   endtask

   task automatic test_clear();
      drive_clean(1'b1, 1'b1, 1'b1);
      n_cmp++;
      if (err_cnt !== '0 || bit_cnt !== '0 || err !== 1'b1 || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL clear_vs_err got ec=%0d bc=%0d e=%b l=%b exp 0 0 1 1",
                  err_cnt, bit_cnt, err, locked);
      end
      drive_clean(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (bit_cnt !== CW'(1) || err_cnt !== '0) begin
         n_bad++;
         $display("FAIL clear_resume got bc=%0d ec=%0d exp bc=1 ec=0", bit_cnt, err_cnt);
      end
   endtask

   task automatic test_random();
      bit v, f, c;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(3) != 0);
         f = ($urandom_range(9) == 0);
         c = ($urandom_range(29) == 0);
         drive_clean(v, f, c);
         n_cmp++;
         if (locked !== (m_mode == 2) || err !== m_err ||
             err_cnt !== CW'(m_errc) || bit_cnt !== CW'(m_bitc)) begin
            n_bad++;
            $display("FAIL random cyc=%0d got l=%b e=%b ec=%0d bc=%0d exp l=%b e=%b ec=%0d bc=%0d",
                     i, locked, err, err_cnt, bit_cnt, m_mode == 2, m_err, m_errc, m_bitc);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 20; i++) drive_clean(1'b1, i == 15, 1'b0);
      @(posedge clk);
      #3;
      ini_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== '0 || bit_cnt !== '0) begin
         n_bad++;
         $display("FAIL async_reset got l=%b e=%b ec=%0d bc=%0d exp all 0",
                  locked, err, err_cnt, bit_cnt);
      end
      @(negedge clk);
      @(negedge clk);
      ini_n = 1'b1;
      gi = 3;
      for (int i = 0; i < 20; i++) begin
         drive_clean(1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (locked !== (m_mode == 2) || locked !== (i >= 11) || err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_relock bit=%0d got l=%b e=%b exp l=%b e=0", i, locked, err, i >= 11);
         end
      end
   endtask

   initial begin
      ini_n = 1'b0; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
      model_reset();
      test_reset();
      test_clean_lock();
      test_single_flip();
      test_loss_of_lock();
      test_all_zero();
      test_gapped();
      test_saturation();
      test_clear();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
